// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter folding NUM_PORTS core request/response ports onto one
// Wishbone classic master, with byte selects and an optional ack timeout.
module wb_master_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             sys_clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req_valid_i,
   output logic [NUM_PORTS-1:0]             req_ready_o,
   input  logic [NUM_PORTS-1:0]             req_we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_sel_i,
   output logic [NUM_PORTS-1:0]             rsp_valid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata_o,
   output logic [NUM_PORTS-1:0]             rsp_err_o,
   output logic                             core_cyc,
   output logic                             core_stb,
   output logic                             core_we,
   output logic [ADDR_WIDTH-1:0]            core_addr,
   output logic [DATA_WIDTH-1:0]            core_data_out,
   output logic [DATA_WIDTH/8-1:0]          core_sel,
   input  logic [DATA_WIDTH-1:0]            core_data_in,
   input  logic                             core_ack,
   output logic                             busy_o
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t                 r_state;
   logic [GW-1:0]          r_last_grant;
   logic [GW-1:0]          r_grant;
   logic [CW-1:0]          r_cnt;
   logic                   r_cyc;
   logic                   r_stb;
   logic                   r_we;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [SW-1:0]          r_sel;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic [NUM_PORTS-1:0]   r_rsp_valid;
   logic [NUM_PORTS-1:0]   r_rsp_err;

   logic [GW-1:0]          w_grant;
   logic [GW-1:0]          w_idx;
   logic                   w_any;
   logic                   w_accept;
   logic [ADDR_WIDTH-1:0]  w_addr  [NUM_PORTS];
   logic [DATA_WIDTH-1:0]  w_wdata [NUM_PORTS];
   logic [SW-1:0]          w_sel   [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign w_addr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_sel[gi]   = req_sel_i[gi*SW +: SW];
         assign req_ready_o[gi] = w_accept && (w_grant == GW'(gi));
         assign rsp_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
      end
   endgenerate

   // Scan from last_grant+k downward in k so the nearest valid port after last_grant wins.
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_idx = GW'((int'(r_last_grant) + k) % NUM_PORTS);
         if (req_valid_i[w_idx]) begin
            w_any   = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   assign w_accept      = rst_n && (r_state == S_IDLE) && w_any;
   assign core_cyc      = r_cyc;
   assign core_stb      = r_stb;
   assign core_we       = r_we;
   assign core_addr     = r_addr;
   assign core_data_out = r_wdata;
   assign core_sel      = r_sel;
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_err_o     = r_rsp_err;
   assign busy_o        = (r_state != S_IDLE);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= GW'(NUM_PORTS - 1);
         r_grant      <= '0;
         r_cnt        <= '0;
         r_cyc        <= 1'b0;
         r_stb        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_sel        <= '0;
         r_rdata      <= '0;
         r_rsp_valid  <= '0;
         r_rsp_err    <= '0;
      end else begin
         r_rsp_valid <= '0;
         r_rsp_err   <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_we         <= req_we_i[w_grant];
                  r_addr       <= w_addr[w_grant];
                  r_wdata      <= w_wdata[w_grant];
                  r_sel        <= w_sel[w_grant];
                  r_grant      <= w_grant;
                  r_last_grant <= w_grant;
                  r_cnt        <= '0;
                  r_cyc        <= 1'b1;
                  r_stb        <= 1'b1;
                  r_state      <= S_BUS;
               end
            end
            S_BUS: begin
               // Ack is tested first so an ack on the final timeout cycle still completes normally.
               if (core_ack) begin
                  r_rdata              <= r_we ? '0 : core_data_in;
                  r_cyc                <= 1'b0;
                  r_stb                <= 1'b0;
                  r_rsp_valid[r_grant] <= 1'b1;
                  r_rsp_err[r_grant]   <= 1'b0;
                  r_state              <= S_RESP;
               end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
                  r_rdata              <= '0;
                  r_cyc                <= 1'b0;
                  r_stb                <= 1'b0;
                  r_rsp_valid[r_grant] <= 1'b1;
                  r_rsp_err[r_grant]   <= 1'b1;
                  r_state              <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: two ports, 8-cycle timeout, hand-computed expectations.
module tb_wb_master_arbiter;

   logic        sys_clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_sel;
   logic [1:0]  rsp_valid;
   logic [63:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        core_cyc, core_stb, core_we;
   logic [31:0] core_addr, core_data_out, core_data_in;
   logic [3:0]  core_sel;
   logic        core_ack;
   logic        busy;

   int checks = 0;
   int errors = 0;

   wb_master_arbiter #(
      .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we),
      .core_addr(core_addr), .core_data_out(core_data_out), .core_sel(core_sel),
      .core_data_in(core_data_in), .core_ack(core_ack), .busy_o(busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request on port p; the slave acks in BUS cycle waitc (negative = never).
   task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input int waitc,
                         input logic [31:0] bus_rd, input logic exp_err, input logic [31:0] exp_rd);
      logic [1:0] onehot;
      int cycles;
      onehot = 2'b00;
      onehot[p] = 1'b1;
      @(negedge sys_clk);
      req_addr  = {2{32'hBAD0_0BAD}};
      req_wdata = {2{32'hA5A5_5A5A}};
      req_sel   = 8'hFF;
      req_we    = {2{~we}};
      req_we[p] = we;
      req_addr[p*32 +: 32]  = addr;
      req_wdata[p*32 +: 32] = wdata;
      req_sel[p*4 +: 4]     = sel;
      req_valid = onehot;
      #1 chk("ready", {62'd0, req_ready}, {62'd0, onehot});
      @(negedge sys_clk);
      req_valid = 2'b00;
      chk("cyc", {63'd0, core_cyc}, 64'd1);
      chk("stb", {63'd0, core_stb}, 64'd1);
      chk("we", {63'd0, core_we}, {63'd0, we});
      chk("addr", {32'd0, core_addr}, {32'd0, addr});
      chk("sel", {60'd0, core_sel}, {60'd0, sel});
      chk("busy", {63'd0, busy}, 64'd1);
      if (we) chk("wdata", {32'd0, core_data_out}, {32'd0, wdata});
      cycles = 1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            chk("cyc_hold", {63'd0, core_cyc}, 64'd1);
            cycles++;
         end
         if (k == waitc) begin
            core_ack     = 1'b1;
            core_data_in = bus_rd;
         end
         @(negedge sys_clk);
         core_ack     = 1'b0;
         core_data_in = 32'h5555_AAAA;
         if (k == waitc) break;
      end
      chk("cyc_drop", {63'd0, core_cyc}, 64'd0);
      chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, onehot});
      chk("rsp_err", {62'd0, rsp_err}, exp_err ? {62'd0, onehot} : 64'd0);
      chk("rsp_rdata", rsp_rdata, {2{exp_rd}});
      @(negedge sys_clk);
      chk("rsp_clear", {62'd0, rsp_valid}, 64'd0);
      chk("idle", {63'd0, busy}, 64'd0);
      $display("txn port=%0d we=%0d addr=%h cyc_cycles=%0d err=%0d rdata=%h",
               p, we, addr, cycles, rsp_err[p], rsp_rdata[31:0]);
   endtask

   logic [1:0]  cont_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [31:0] cont_addr  [4] = '{32'h0000_0A00, 32'h0000_0B00, 32'h0000_0A00, 32'h0000_0B00};

   initial begin
      rst_n        = 1'b0;
      req_valid    = 2'b00;
      req_we       = 2'b00;
      req_addr     = '0;
      req_wdata    = '0;
      req_sel      = '0;
      core_ack     = 1'b0;
      core_data_in = '0;

      // Reset state
      #2;
      chk("rst_cyc", {63'd0, core_cyc}, 64'd0);
      chk("rst_stb", {63'd0, core_stb}, 64'd0);
      chk("rst_bus", {core_addr, core_data_out}, 64'd0);
      chk("rst_misc", {53'd0, core_we, core_sel, rsp_valid, rsp_err, busy}, 64'd0);
      chk("rst_rdata", rsp_rdata, 64'd0);
      chk("rst_ready", {62'd0, req_ready}, 64'd0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;

      // Single read, 2 wait states
      do_txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
      // Byte write from port 1; response data must be zero
      do_txn(1, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'b0010, 0, 32'hFFFF_FFFF, 1'b0, 32'h0);

      // Contention: both ports valid continuously, zero-wait slave
      @(negedge sys_clk);
      req_we    = 2'b00;
      req_sel   = 8'hFF;
      req_addr  = {32'h0000_0B00, 32'h0000_0A00};
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 chk("cont_ready", {62'd0, req_ready}, {62'd0, cont_ready[i]});
         @(negedge sys_clk);
         chk("cont_cyc", {63'd0, core_cyc}, 64'd1);
         chk("cont_addr", {32'd0, core_addr}, {32'd0, cont_addr[i]});
         chk("cont_busy_ready", {62'd0, req_ready}, 64'd0);
         core_ack     = 1'b1;
         core_data_in = 32'h0000_1000 + i;
         @(negedge sys_clk);
         core_ack = 1'b0;
         chk("cont_rsp", {62'd0, rsp_valid}, {62'd0, cont_ready[i]});
         chk("cont_rdata", {32'd0, rsp_rdata[31:0]}, {32'd0, 32'h0000_1000 + i});
         $display("txn contention idx=%0d ready=%b addr=%h", i, cont_ready[i], cont_addr[i]);
         @(negedge sys_clk);
      end
      req_valid = 2'b00;

      // Timeout: no ack for 8 cycles, then a normal request
      do_txn(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, -1, 32'h7777_7777, 1'b1, 32'h0);
      do_txn(1, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);
      // Ack on the 8th BUS cycle collides with the timeout; ack wins
      do_txn(0, 1'b0, 32'h0000_0308, 32'h0, 4'hF, 7, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);

      // Reset mid-BUS
      @(negedge sys_clk);
      req_we    = 2'b00;
      req_addr  = {32'h0000_0400, 32'h0000_0500};
      req_valid = 2'b10;
      @(negedge sys_clk);
      req_valid = 2'b00;
      chk("mid_cyc", {63'd0, core_cyc}, 64'd1);
      @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cyc", {63'd0, core_cyc}, 64'd0);
      chk("mid_rst_stb", {63'd0, core_stb}, 64'd0);
      chk("mid_rst_rsp", {62'd0, rsp_valid}, 64'd0);
      @(negedge sys_clk);
      chk("mid_rst_rsp2", {62'd0, rsp_valid}, 64'd0);
      rst_n = 1'b1;
      @(negedge sys_clk);
      chk("post_rst_rsp", {62'd0, rsp_valid}, 64'd0);
      chk("post_rst_cyc", {63'd0, core_cyc}, 64'd0);
      req_valid = 2'b11;
      #1 chk("post_rst_grant", {62'd0, req_ready}, 64'd1);
      @(negedge sys_clk);
      req_valid = 2'b00;
      chk("post_rst_addr", {32'd0, core_addr}, {32'd0, 32'h0000_0500});
      core_ack     = 1'b1;
      core_data_in = 32'h0101_0101;
      @(negedge sys_clk);
      core_ack = 1'b0;
      chk("post_rst_rsp_valid", {62'd0, rsp_valid}, 64'd1);
      $display("txn post-reset port=0 rdata=%h", rsp_rdata[31:0]);
      @(negedge sys_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Parametrised successor to the fixed single-master core-to-bus hookup in the processorci top level, where `core_cyc`/`core_stb` are tied high. This block accepts `NUM_PORTS` independent core-native request/response ports, for example instruction and data, and arbitrates them round-robin onto one Wishbone classic master. It drives real `cyc`/`stb` handshakes, byte selects and a bus timeout, and sits between the core and the Controller (or the simulation bus).

## Interface
Parameters:
- `NUM_PORTS`, 2: number of core request ports, 1..4.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; a multiple of 8.
- `TIMEOUT_CYCLES`, 255: maximum `core_ack` wait in cycles; 0 disables the timeout.

Ports (vectors are flattened with port i in slice i):
- `sys_clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NUM_PORTS: request pending, per port.
- `req_ready_o` out NUM_PORTS: request accepted this cycle.
- `req_we_i` in NUM_PORTS: 1 = write.
- `req_addr_i` in NUM_PORTS*ADDR_WIDTH: request address.
- `req_wdata_i` in NUM_PORTS*DATA_WIDTH: write data.
- `req_sel_i` in NUM_PORTS*DATA_WIDTH/8: byte enables.
- `rsp_valid_o` out NUM_PORTS: one-cycle response strobe.
- `rsp_rdata_o` out NUM_PORTS*DATA_WIDTH: read data; the same value is broadcast to all slices.
- `rsp_err_o` out NUM_PORTS: valid with `rsp_valid_o`; 1 = timeout.
- `core_cyc`, `core_stb`, `core_we` out 1: Wishbone master controls.
- `core_addr` out ADDR_WIDTH; `core_data_out` out DATA_WIDTH; `core_sel` out DATA_WIDTH/8.
- `core_data_in` in DATA_WIDTH: Wishbone read data.
- `core_ack` in 1: Wishbone acknowledge.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
The FSM has three states: IDLE, BUS and RESP.

IDLE:
- Grant goes to the first port with `req_valid_i` set, searching upward from `last_grant+1` modulo `NUM_PORTS`.
- `req_ready_o[grant]` is combinationally high, for exactly one port at most.
- On valid&ready the block latches we, addr, wdata, sel and the grant index, updates `last_grant`, and moves to BUS.
- If no port is valid, it stays in IDLE.

BUS:
- `core_cyc`=`core_stb`=1, and the latched fields are driven on the bus.
- The timeout counter clears on entry and increments each cycle without ack.
- On `core_ack`=1: latch `core_data_in` (reads) or zero (writes), set err=0, move to RESP.
- If the counter reaches `TIMEOUT_CYCLES` (nonzero) with no ack: set err=1, rdata=0, move to RESP.
- Ack on the same cycle as the timeout is treated as ack and wins.

RESP:
- `rsp_valid_o[grant]`=1 for one cycle with `rsp_err_o[grant]`=err, then return to IDLE.

Other rules:
- `core_ack` is ignored in IDLE and RESP.
- Requesters hold their request stable until ready. Changes while not ready are allowed; only the accepted cycle is latched.
- `last_grant` resets to `NUM_PORTS-1`, so port 0 wins the first contention.
- When `NUM_PORTS`=1, arbitration degenerates to a pass-through of port 0.

Reset values:
- All outputs are 0.
- State is IDLE.
- The counter and latched fields are 0.
- Reset asserted mid-BUS drops `cyc`/`stb` immediately (asynchronously), and no response is issued for that request.

## Timing
- Accept at cycle T. `cyc`/`stb` are high from T+1. Ack is sampled at T+1+w, where w is the number of wait states (w≥0). `rsp_valid` is asserted at T+2+w. IDLE is reached at T+3+w.
- A new request is accepted no earlier than T+3+w. With zero-wait slaves, throughput is one transfer per 3 cycles.
- On timeout, `cyc`/`stb` are high for exactly `TIMEOUT_CYCLES` cycles, and `rsp_valid` follows in the next cycle.
- All bus outputs and `rsp_*` are registered. Only `req_ready_o` is combinational (from `req_valid_i` and the state).

## Test plan
- **Single read:** port 0 reads 0x100; the slave acks 2 cycles after `stb` with 0xDEADBEEF -> `rsp_valid_o[0]` at T+4, rdata=0xDEADBEEF, err=0, `core_we`=0.
- **Byte write:** port 1 writes 0x12345678 with sel=4'b0010 to 0x204 -> bus shows we=1, sel=0010, addr 0x204, data 0x12345678; response err=0, rdata=0.
- **Contention:** ports 0 and 1 are both valid continuously with zero-wait acks -> grants alternate 0,1,0,1 over 4 transactions, with accepts spaced 3 cycles apart.
- **Timeout:** `TIMEOUT_CYCLES`=8 and no ack -> `cyc` high for 8 cycles, then `rsp_err_o`=1 and rdata=0; the next request proceeds normally.
- **Ack/timeout collision:** ack arrives on the 8th wait cycle with `TIMEOUT_CYCLES`=8 -> err=0 and data is captured.
- **Reset mid-BUS:** `rst_n` is pulled low 1 cycle after `stb` rises -> `cyc`/`stb` fall in the same cycle and no `rsp_valid` appears. After release, port 0 is granted first.
